// File: rtl/soc_dma_buf_sched_if.sv
// rtl/soc_dma_buf_sched_if.sv - Avalon-MM register, line-trigger and DMA handshake bundle for soc_dma_buf_sched
interface soc_dma_buf_sched_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        line_req;
  logic        dma_start;
  logic [31:0] dma_addr;
  logic        dma_done;
  logic        dma_error;

  // Scheduler side
  modport slave (
    input  address, write, writedata, line_req, dma_done, dma_error,
    output readdata, irq, dma_start, dma_addr
  );

  // Software / trigger / DMA side
  modport master (
    output address, write, writedata, line_req, dma_done, dma_error,
    input  readdata, irq, dma_start, dma_addr
  );
endinterface

// File: rtl/soc_dma_buf_sched.sv
// rtl/soc_dma_buf_sched.sv - Ring-buffer DMA line scheduler; optional macro SOC_DMA_SCHED_TIMESTAMP_EN adds per-slot timestamps on register 4
module soc_dma_buf_sched #(
  parameter int          NBUF       = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0000_4000
) (
  input logic                clk,
  input logic                reset_n,
  soc_dma_buf_sched_if.slave bus
);
  localparam logic [4:0] NBUF_FILL = 5'(NBUF);
  localparam logic [3:0] LAST_IDX  = 4'(NBUF - 1);
  localparam int         IW        = $clog2(NBUF);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t      state;
  logic        enable;
  logic        irq_en;
  logic        overrun;
  logic        dma_err;
  logic [4:0]  fill;
  logic [3:0]  sw_idx;
  logic [3:0]  hw_idx;
  logic [15:0] drop_cnt;
  logic [31:0] rd_mux;
  logic [31:0] ts_rd;

  function automatic logic [3:0] next_idx(input logic [3:0] idx);
    return (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
  endfunction

  logic [31:0] hw_addr;
  logic [31:0] sw_addr;
  assign hw_addr = BASE_ADDR + {28'd0, hw_idx} * BUF_STRIDE;
  assign sw_addr = BASE_ADDR + {28'd0, sw_idx} * BUF_STRIDE;

  logic wr_ctrl, wr_status, wr_release, wr_drop, ring_clr;
  assign wr_ctrl    = bus.write && (bus.address == 3'd0);
  assign wr_status  = bus.write && (bus.address == 3'd1);
  assign wr_release = bus.write && (bus.address == 3'd2);
  assign wr_drop    = bus.write && (bus.address == 3'd3);
  assign ring_clr   = wr_ctrl && bus.writedata[2];

  // Event decode; a line_req that is not accepted is always a drop, and it
  // only counts as an overrun when the ring was supposed to be capturing.
  logic accept, drop_line, drop_ovr, commit, xfer_err, release_ok;
  assign accept     = (state == IDLE) && bus.line_req && enable && (fill < NBUF_FILL);
  assign drop_line  = bus.line_req && !accept;
  assign drop_ovr   = drop_line && ((state != IDLE) || enable);
  assign commit     = (state == RUN) && bus.dma_done && !bus.dma_error;
  assign xfer_err   = (state == RUN) && bus.dma_error;
  assign release_ok = wr_release && (fill != 5'd0);

  logic unused_wdata;
  assign unused_wdata = ^{bus.writedata[31:18], bus.writedata[15:3]};

`ifdef SOC_DMA_SCHED_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] ts_mem [NBUF];

  // Free-running cycle counter; its value is captured into the slot being armed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 32'd0;
      for (int i = 0; i < NBUF; i++) ts_mem[i] <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept && !ring_clr) ts_mem[hw_idx[IW-1:0]] <= cycle_cnt;
    end
  end

  assign ts_rd = ts_mem[sw_idx[IW-1:0]];
`else
  assign ts_rd = 32'd0;
`endif

  // Register read mux, registered below for one cycle of read latency
  always_comb begin
    rd_mux = 32'd0;
    case (bus.address)
      3'd0:    rd_mux = {30'd0, irq_en, enable};
      3'd1:    rd_mux = {13'd0, state != IDLE, dma_err, overrun, hw_idx, sw_idx, 3'd0, fill};
      3'd2:    rd_mux = sw_addr;
      3'd3:    rd_mux = {16'd0, drop_cnt};
      3'd4:    rd_mux = ts_rd;
      default: rd_mux = 32'd0;
    endcase
  end

  // Registered read data and level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 32'd0;
      bus.irq      <= 1'b0;
    end else begin
      bus.readdata <= rd_mux;
      bus.irq      <= irq_en && ((fill != 5'd0) || overrun || dma_err);
    end
  end

  // Scheduler FSM with ring bookkeeping; set events win over same-cycle software clears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      enable        <= 1'b0;
      irq_en        <= 1'b0;
      overrun       <= 1'b0;
      dma_err       <= 1'b0;
      fill          <= 5'd0;
      sw_idx        <= 4'd0;
      hw_idx        <= 4'd0;
      drop_cnt      <= 16'd0;
      bus.dma_start <= 1'b0;
      bus.dma_addr  <= 32'd0;
    end else if (ring_clr) begin
      enable        <= bus.writedata[0];
      irq_en        <= bus.writedata[1];
      state         <= IDLE;
      overrun       <= 1'b0;
      dma_err       <= 1'b0;
      fill          <= 5'd0;
      sw_idx        <= 4'd0;
      hw_idx        <= 4'd0;
      drop_cnt      <= 16'd0;
      bus.dma_start <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= bus.writedata[0];
        irq_en <= bus.writedata[1];
      end

      if (xfer_err)                            dma_err <= 1'b1;
      else if (wr_status && bus.writedata[17]) dma_err <= 1'b0;

      if (drop_ovr)                            overrun <= 1'b1;
      else if (wr_status && bus.writedata[16]) overrun <= 1'b0;

      if (drop_line) begin
        if (wr_drop)                    drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
      end else if (wr_drop) begin
        drop_cnt <= 16'd0;
      end

      if (commit)     hw_idx <= next_idx(hw_idx);
      if (release_ok) sw_idx <= next_idx(sw_idx);
      case ({commit, release_ok})
        2'b10:   fill <= fill + 5'd1;
        2'b01:   fill <= fill - 5'd1;
        default: fill <= fill;
      endcase

      bus.dma_start <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state         <= ARM;
          bus.dma_start <= 1'b1;
          bus.dma_addr  <= hw_addr;
        end
        ARM:  state <= RUN;
        RUN:  if (bus.dma_done || bus.dma_error) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_dma_buf_sched.sv
// tb/tb_soc_dma_buf_sched.sv - Self-checking bench for soc_dma_buf_sched with a ring-level reference model
module tb_soc_dma_buf_sched;
  localparam int          NBUF   = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] STRIDE = 32'h0000_4000;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ncyc = 0;

  soc_dma_buf_sched_if bus_if ();

  soc_dma_buf_sched #(.NBUF(NBUF), .BASE_ADDR(BASE), .BUF_STRIDE(STRIDE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  always @(posedge clk) if (reset_n) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: ring as running produced/consumed totals, transfer as age since acceptance
  int          m_hw, m_sw, m_drop, m_age;
  bit          m_en, m_ien, m_ovr, m_derr;
  logic [31:0] m_xaddr, m_cnt;
  logic [31:0] m_ts [NBUF];
  logic [31:0] e_rd;
  bit          e_irq, e_start;

  function automatic logic [31:0] slot_addr(input int n);
    return BASE + 32'(n % NBUF) * STRIDE;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hw = 0; m_sw = 0; m_drop = 0; m_age = -1;
      m_en = 0; m_ien = 0; m_ovr = 0; m_derr = 0;
      m_xaddr = 0; m_cnt = 0;
      for (int i = 0; i < NBUF; i++) m_ts[i] = 0;
      e_rd = 0; e_irq = 0; e_start = 0;
    end else begin
      int          fill;
      bit          w, lr, dd, de, en_pre, acc, done_now, commit, err, rel;
      logic [2:0]  a;
      logic [31:0] wd;
      a = bus_if.address; w = bus_if.write; wd = bus_if.writedata;
      lr = bus_if.line_req; dd = bus_if.dma_done; de = bus_if.dma_error;
      fill = m_hw - m_sw;
      case (a)
        3'd0: e_rd = {30'd0, m_ien, m_en};
        3'd1: e_rd = {13'd0, 1'(m_age >= 0), m_derr, m_ovr, 4'(m_hw % NBUF), 4'(m_sw % NBUF), 3'd0, 5'(fill)};
        3'd2: e_rd = slot_addr(m_sw);
        3'd3: e_rd = 32'(m_drop);
`ifdef SOC_DMA_SCHED_TIMESTAMP_EN
        3'd4: e_rd = m_ts[m_sw % NBUF];
`else
        3'd4: e_rd = 32'd0;
`endif
        default: e_rd = 32'd0;
      endcase
      e_irq = m_ien && (fill != 0 || m_ovr || m_derr);
      if (w && a == 3'd0 && wd[2]) begin
        m_en = wd[0]; m_ien = wd[1];
        m_hw = 0; m_sw = 0; m_drop = 0; m_ovr = 0; m_derr = 0; m_age = -1;
      end else begin
        en_pre   = m_en;
        acc      = lr && m_age < 0 && m_en && fill < NBUF;
        done_now = m_age >= 1 && (dd || de);
        commit   = m_age >= 1 && dd && !de;
        err      = m_age >= 1 && de;
        rel      = w && a == 3'd2 && fill > 0;
        if (w && a == 3'd1) begin
          if (wd[16]) m_ovr = 0;
          if (wd[17]) m_derr = 0;
        end
        if (w && a == 3'd3) m_drop = 0;
        if (w && a == 3'd0) begin m_en = wd[0]; m_ien = wd[1]; end
        if (lr && !acc) begin
          if (m_drop < 65535) m_drop++;
          if (m_age >= 0 || en_pre) m_ovr = 1;
        end
        if (err) m_derr = 1;
        if (acc) begin
          m_xaddr = slot_addr(m_hw);
          m_ts[m_hw % NBUF] = m_cnt;
          m_age = 0;
        end else if (done_now) m_age = -1;
        else if (m_age == 0) m_age = 1;
        if (commit) m_hw++;
        if (rel) m_sw++;
      end
      e_start = (m_age == 0);
      m_cnt = m_cnt + 32'd1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("readdata", bus_if.readdata, e_rd);
    check("irq", {31'd0, bus_if.irq}, {31'd0, e_irq});
    check("dma_start", {31'd0, bus_if.dma_start}, {31'd0, e_start});
    if (m_age >= 0) check("dma_addr", bus_if.dma_addr, m_xaddr);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_if.address = a; bus_if.write = 1'b1; bus_if.writedata = d;
    cyc();
    bus_if.write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus_if.address = a;
    cyc();
    d = bus_if.readdata;
  endtask

  task automatic pulse_line();
    bus_if.line_req = 1'b1;
    cyc();
    bus_if.line_req = 1'b0;
  endtask

  task automatic pulse_done();
    bus_if.dma_done = 1'b1;
    cyc();
    bus_if.dma_done = 1'b0;
  endtask

  task automatic pulse_error();
    bus_if.dma_error = 1'b1;
    cyc();
    bus_if.dma_error = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    reset_n = 1'b0;
    bus_if.address = 3'd0; bus_if.write = 1'b0; bus_if.writedata = 32'd0;
    bus_if.line_req = 1'b0; bus_if.dma_done = 1'b0; bus_if.dma_error = 1'b0;
    repeat (3) cyc();
    check("reset_readdata", bus_if.readdata, 32'd0);
    check("reset_irq", {31'd0, bus_if.irq}, 32'd0);
    check("reset_dma_start", {31'd0, bus_if.dma_start}, 32'd0);
    check("reset_dma_addr", bus_if.dma_addr, 32'd0);
    reset_n = 1'b1;

    // Timestamp capture at counter value 100
    wr(3'd0, 32'h3);
    while (ncyc < 100) cyc();
    pulse_line();
    repeat (3) cyc();
    pulse_done();
    rd(3'd4, r);
`ifdef SOC_DMA_SCHED_TIMESTAMP_EN
    check("tstamp_100", r, 32'd100);
`else
    check("tstamp_off", r, 32'd0);
`endif
    wr(3'd0, 32'h7);

    // First transfer
    pulse_line();
    check("first_start", {31'd0, bus_if.dma_start}, 32'd1);
    check("first_addr", bus_if.dma_addr, 32'h0);
    cyc();
    check("start_one_cycle", {31'd0, bus_if.dma_start}, 32'd0);
    repeat (8) cyc();
    pulse_done();
    rd(3'd1, r);
    check("status_after_first", r, 32'h0000_1001);
    check("irq_fill", {31'd0, bus_if.irq}, 32'd1);

    // Fill the ring, then overflow
    for (int i = 0; i < 3; i++) begin
      pulse_line();
      repeat (3) cyc();
      pulse_done();
    end
    pulse_line();
    check("full_no_start", {31'd0, bus_if.dma_start}, 32'd0);
    rd(3'd3, r);
    check("drop_full", r, 32'd1);
    rd(3'd1, r);
    check("status_full", r, 32'h0001_0004);
    rd(3'd2, r);
    check("release_addr0", r, 32'h0);
    wr(3'd2, 32'd0);
    rd(3'd1, r);
    check("status_release", r, 32'h0001_0103);
    rd(3'd2, r);
    check("release_addr1", r, 32'h4000);

    // Commit and release in the same cycle with fill=2
    wr(3'd2, 32'd0);
    pulse_line();
    cyc();
    bus_if.dma_done = 1'b1; bus_if.address = 3'd2; bus_if.write = 1'b1;
    cyc();
    bus_if.dma_done = 1'b0; bus_if.write = 1'b0;
    rd(3'd1, r);
    check("status_commit_release", r, 32'h0001_1302);

    // Errored transfer, then clear stickies
    pulse_line();
    check("err_xfer_addr", bus_if.dma_addr, 32'h4000);
    cyc();
    pulse_error();
    rd(3'd1, r);
    check("status_err", r, 32'h0003_1302);
    wr(3'd2, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'h0001_0000);
    rd(3'd1, r);
    check("status_err_only", r, 32'h0002_1100);
    check("irq_err_only", {31'd0, bus_if.irq}, 32'd1);
    wr(3'd1, 32'h0002_0000);
    cyc();
    check("irq_cleared", {31'd0, bus_if.irq}, 32'd0);

    // Drop in RUN, ring_clr in RUN, late done
    wr(3'd3, 32'd0);
    pulse_line();
    cyc();
    pulse_line();
    rd(3'd3, r);
    check("drop_in_run", r, 32'd1);
    wr(3'd0, 32'h7);
    pulse_done();
    rd(3'd1, r);
    check("status_after_clr", r, 32'd0);
    rd(3'd3, r);
    check("drop_after_clr", r, 32'd0);
    rd(3'd0, r);
    check("ctrl_clr_reads0", r, 32'h3);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] wd;
      bus_if.address   = 3'($urandom_range(0, 7));
      bus_if.line_req  = ($urandom % 4) == 0;
      bus_if.dma_done  = ($urandom % 5) == 0;
      bus_if.dma_error = ($urandom % 24) == 0;
      bus_if.write     = ($urandom % 5) == 0;
      if (bus_if.write && ($urandom % 2) == 0) bus_if.address = 3'd2;
      wd = $urandom;
      if (bus_if.address == 3'd0) begin
        wd[0] = ($urandom % 8) != 0;
        wd[2] = ($urandom % 40) == 0;
      end
      bus_if.writedata = wd;
      cyc();
    end
    bus_if.write = 1'b0; bus_if.line_req = 1'b0;
    bus_if.dma_done = 1'b0; bus_if.dma_error = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
